fetch_hazard_ctrl: RTL and testbench
====================================

FETCH_HAZARD_CTRL -- requirements
Module: fetch_hazard_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and one reset: reset is asynchronous and active-low.
REQ-002 Ports, in order (name  direction  width  meaning):
- I_CLOCK  in  1  clock; all state updates on posedge.
- I_RESET_N  in  1  asynchronous active-low reset.
- I_LOCK  in  1  pipeline enable; 0 holds the block in its reset state.
- I_DE_Valid  in  1  decode holds a real instruction (not a FetchStall NOP).
- I_DE_Src1 / I_DE_Src2  in  4 each  source register indices.
- I_DE_Src1Used / I_DE_Src2Used  in  1 each  source is read.
- I_DE_Dest  in  4  destination register index.
- I_DE_DestWrite  in  1  instruction writes I_DE_Dest.
- I_DE_IsBranch  in  1  instruction is a branch or jump.
- I_WB_Valid  in  1  writeback retires a register write this cycle.
- I_WB_Dest  in  4  register retired.
- I_MEM_BranchResolved  in  1  branch target resolved this cycle.
- I_MEM_BranchPC  in  16  resolved target.
- O_DepStallSignal  out  1  register-dependency stall to fetch/decode.
- O_BranchStallSignal  out  1  branch-in-flight stall to fetch.
- O_BranchAddrSelect  out  1  one-cycle redirect strobe to fetch.
- O_BranchPC  out  16  redirect target, valid while O_BranchAddrSelect=1.
- O_Issue  out  1  decode instruction accepted this cycle.

Function
REQ-003 Scoreboard: 16 entries of 2-bit pending-write counters, one per register.
REQ-004 Hazard (combinational): I_DE_Valid and (Src1Used and cnt[Src1]!=0, or Src2Used and cnt[Src2]!=0, or DestWrite and cnt[Dest]==3).
REQ-005 O_DepStallSignal SHALL equal the hazard term gated by I_LOCK, combinational in the same cycle.
REQ-006 O_Issue = I_LOCK and I_DE_Valid and not O_DepStallSignal and state==IDLE.
REQ-007 On O_Issue with DestWrite: cnt[Dest] increments at the next posedge.
REQ-008 On I_WB_Valid: cnt[WB_Dest] decrements at the next posedge; a decrement at 0 SHALL leave 0 and never wrap.
REQ-009 Increment and decrement of the same register in one cycle SHALL leave the counter unchanged.
REQ-010 Branch FSM states: IDLE, WAIT, REDIRECT.
- IDLE->WAIT on O_Issue with I_DE_IsBranch.
- WAIT->REDIRECT on I_MEM_BranchResolved; I_MEM_BranchPC is captured into O_BranchPC.
- REDIRECT->IDLE unconditionally after one cycle.
REQ-011 O_BranchStallSignal=1 in WAIT and REDIRECT; O_BranchAddrSelect=1 only in REDIRECT (registered, exactly one cycle).
REQ-012 I_MEM_BranchResolved in IDLE or REDIRECT SHALL be ignored.
REQ-013 Scoreboard updates from WB SHALL continue in every FSM state.
REQ-014 Branch and dependency stall MAY assert together; fetch gives dependency stall priority.

Reset
REQ-015 I_RESET_N=0 SHALL immediately clear all counters, force state IDLE, O_BranchPC=16'h0, and drive every output 0, including mid-branch.
REQ-016 While I_LOCK=0 the block SHALL behave as held in reset (synchronous clear at each posedge); outputs 0.

Configuration
REQ-017 Macro HAZARD_WB_BYPASS_EN.
- Defined: a source whose register equals I_WB_Dest with I_WB_Valid=1 and cnt==1 is not a hazard that cycle (same-cycle writeback forwarding).
- Undefined: that source stalls until the counter reads 0 (one extra stall cycle).

Verification
REQ-018 Issue write R3, then a reader of R3 the next cycle -> O_DepStallSignal=1 until WB of R3; cycle count differs by exactly 1 with/without HAZARD_WB_BYPASS_EN.
REQ-019 Three writers of R5 in flight, fourth writer of R5 presented -> stall (cnt==3); one WB of R5 -> fourth issues, cnt stays 3.
REQ-020 Issue branch, resolve 4 cycles later with PC 16'h0040 -> O_BranchStallSignal high 5 cycles; O_BranchAddrSelect high exactly one cycle with O_BranchPC=16'h0040.
REQ-021 Issue writer of R7 and WB of R7 in the same cycle from cnt=1 -> cnt remains 1; WB of R2 with cnt=0 -> cnt stays 0.
REQ-022 Assert I_RESET_N=0 in WAIT with cnt[R1]=2 -> all outputs 0 asynchronously; after release, reader of R1 issues with no stall.
REQ-023 Pulse I_MEM_BranchResolved in IDLE -> no O_BranchAddrSelect pulse and no state change.

Source files
------------

// File: rtl/fetch_hazard_ctrl.sv
// Register scoreboard and branch-redirect controller for fetch/decode; dependency stall and issue are combinational, branch outputs registered.
// Optional HAZARD_WB_BYPASS_EN lets a source whose last pending write retires this cycle issue without waiting.
module fetch_hazard_ctrl (
  input  logic        I_CLOCK,
  input  logic        I_RESET_N,
  input  logic        I_LOCK,
  input  logic        I_DE_Valid,
  input  logic [3:0]  I_DE_Src1,
  input  logic [3:0]  I_DE_Src2,
  input  logic        I_DE_Src1Used,
  input  logic        I_DE_Src2Used,
  input  logic [3:0]  I_DE_Dest,
  input  logic        I_DE_DestWrite,
  input  logic        I_DE_IsBranch,
  input  logic        I_WB_Valid,
  input  logic [3:0]  I_WB_Dest,
  input  logic        I_MEM_BranchResolved,
  input  logic [15:0] I_MEM_BranchPC,
  output logic        O_DepStallSignal,
  output logic        O_BranchStallSignal,
  output logic        O_BranchAddrSelect,
  output logic [15:0] O_BranchPC,
  output logic        O_Issue
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT     = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [1:0]  cnt_q [16];
  logic [1:0]  cnt_d [16];

  logic        wb_fwd1, wb_fwd2;
  logic        src1_haz, src2_haz, dest_haz;
  logic        hazard, dep_stall, issue;
  logic [15:0] inc_vec, dec_vec;

`ifdef HAZARD_WB_BYPASS_EN
  // The only outstanding write to this source retires now, so the value is on the WB bus.
  assign wb_fwd1 = I_WB_Valid && (I_WB_Dest == I_DE_Src1) && (cnt_q[I_DE_Src1] == 2'd1);
  assign wb_fwd2 = I_WB_Valid && (I_WB_Dest == I_DE_Src2) && (cnt_q[I_DE_Src2] == 2'd1);
`else
  assign wb_fwd1 = 1'b0;
  assign wb_fwd2 = 1'b0;
`endif

  assign src1_haz  = I_DE_Src1Used && (cnt_q[I_DE_Src1] != 2'd0) && !wb_fwd1;
  assign src2_haz  = I_DE_Src2Used && (cnt_q[I_DE_Src2] != 2'd0) && !wb_fwd2;
  assign dest_haz  = I_DE_DestWrite && (cnt_q[I_DE_Dest] == 2'd3);
  assign hazard    = I_DE_Valid && (src1_haz || src2_haz || dest_haz);
  assign dep_stall = I_LOCK && hazard;
  assign issue     = I_LOCK && I_DE_Valid && !dep_stall && (state_q == ST_IDLE);

  assign inc_vec = (issue && I_DE_DestWrite) ? (16'h0001 << I_DE_Dest) : 16'h0000;
  assign dec_vec = I_WB_Valid ? (16'h0001 << I_WB_Dest) : 16'h0000;

  always_comb begin
    for (int i = 0; i < 16; i++) begin
      cnt_d[i] = cnt_q[i];
      if (inc_vec[i] && !dec_vec[i]) begin
        cnt_d[i] = cnt_q[i] + 2'd1;
      end else if (dec_vec[i] && !inc_vec[i] && (cnt_q[i] != 2'd0)) begin
        cnt_d[i] = cnt_q[i] - 2'd1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE: begin
        if (issue && I_DE_IsBranch) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (I_MEM_BranchResolved) begin
          state_d = ST_REDIRECT;
          pc_d    = I_MEM_BranchPC;
        end
      end
      ST_REDIRECT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Dropping I_LOCK is a synchronous flush back to the reset image.
  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q <= ST_IDLE;
      pc_q    <= 16'h0000;
      for (int i = 0; i < 16; i++) begin
        cnt_q[i] <= 2'd0;
      end
    end else if (!I_LOCK) begin
      state_q <= ST_IDLE;
      pc_q    <= 16'h0000;
      for (int i = 0; i < 16; i++) begin
        cnt_q[i] <= 2'd0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      for (int i = 0; i < 16; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Combinational outputs are gated so reset and lock-low read as all-zero at once.
  assign O_DepStallSignal    = dep_stall && I_RESET_N;
  assign O_Issue             = issue && I_RESET_N;
  assign O_BranchStallSignal = I_LOCK && (state_q != ST_IDLE);
  assign O_BranchAddrSelect  = I_LOCK && (state_q == ST_REDIRECT);
  assign O_BranchPC          = I_LOCK ? pc_q : 16'h0000;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Directed bench for fetch_hazard_ctrl: scoreboard hazards, branch FSM, reset and lock behaviour.
module tb_fetch_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, lock;
  logic        de_valid, s1u, s2u, dw, isbr, wb_valid, mem_res;
  logic [3:0]  src1, src2, dest, wb_dest;
  logic [15:0] mem_pc;
  logic        o_dep, o_bstall, o_asel, o_issue;
  logic [15:0] o_pc;

  int checks = 0;
  int errors = 0;
  int stall_cycles, bstall_cnt, asel_cnt;

`ifdef HAZARD_WB_BYPASS_EN
  localparam int EXP_STALL = 2;
`else
  localparam int EXP_STALL = 3;
`endif

  fetch_hazard_ctrl dut (
    .I_CLOCK              (clk),
    .I_RESET_N            (rst_n),
    .I_LOCK               (lock),
    .I_DE_Valid           (de_valid),
    .I_DE_Src1            (src1),
    .I_DE_Src2            (src2),
    .I_DE_Src1Used        (s1u),
    .I_DE_Src2Used        (s2u),
    .I_DE_Dest            (dest),
    .I_DE_DestWrite       (dw),
    .I_DE_IsBranch        (isbr),
    .I_WB_Valid           (wb_valid),
    .I_WB_Dest            (wb_dest),
    .I_MEM_BranchResolved (mem_res),
    .I_MEM_BranchPC       (mem_pc),
    .O_DepStallSignal     (o_dep),
    .O_BranchStallSignal  (o_bstall),
    .O_BranchAddrSelect   (o_asel),
    .O_BranchPC           (o_pc),
    .O_Issue              (o_issue)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    de_valid = 0; s1u = 0; s2u = 0; dw = 0; isbr = 0;
    src1 = 0; src2 = 0; dest = 0;
    wb_valid = 0; wb_dest = 0; mem_res = 0;
  endtask

  task automatic writer(input logic [3:0] r);
    clear_in();
    de_valid = 1; dw = 1; dest = r;
  endtask

  task automatic reader1(input logic [3:0] r);
    clear_in();
    de_valid = 1; s1u = 1; src1 = r;
  endtask

  initial begin
    rst_n = 0; lock = 1; mem_pc = 16'h0;
    clear_in();
    de_valid = 1;
    #2;
    chk("rst_issue", o_issue, 0);
    chk("rst_dep", o_dep, 0);
    chk("rst_bstall", o_bstall, 0);
    chk("rst_asel", o_asel, 0);
    chk("rst_pc", o_pc, 16'h0);
    clear_in();
    @(negedge clk);
    rst_n = 1;
    tick();

    // same-cycle inc/dec and saturating decrement
    writer(4'd7); #1;
    chk("w7_issue", o_issue, 1);
    chk("w7_dep", o_dep, 0);
    tick();
    chk("cnt7_one", dut.cnt_q[7], 1);
    wb_valid = 1; wb_dest = 4'd7; #1;
    chk("w7_wb_issue", o_issue, 1);
    tick();
    chk("cnt7_incdec", dut.cnt_q[7], 1);
    clear_in(); wb_valid = 1; wb_dest = 4'd2;
    tick();
    chk("cnt2_sat", dut.cnt_q[2], 0);
    clear_in(); wb_valid = 1; wb_dest = 4'd7;
    tick();
    chk("cnt7_drain", dut.cnt_q[7], 0);

    // RAW on R3, writeback on third stalled cycle
    writer(4'd3); #1;
    chk("w3_issue", o_issue, 1);
    tick();
    reader1(4'd3);
    stall_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      wb_valid = (i == 2); wb_dest = 4'd3;
      #1;
      if (i == 0) chk("raw_first_stall", o_dep, 1);
      if (o_issue) break;
      stall_cycles++;
      tick();
    end
    tick();
    chk("raw_stall_cycles", stall_cycles, EXP_STALL);
    chk("cnt3_zero", dut.cnt_q[3], 0);

    // Src2 hazard, and unused source ignored
    writer(4'd4);
    tick();
    clear_in(); de_valid = 1; src2 = 4'd4; s2u = 1; #1;
    chk("src2_dep", o_dep, 1);
    s2u = 0; #1;
    chk("src2_unused_dep", o_dep, 0);
    chk("src2_unused_issue", o_issue, 1);
    tick();
    clear_in(); wb_valid = 1; wb_dest = 4'd4;
    tick();

    // three writers of R5 in flight, fourth waits for one WB
    writer(4'd5);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("w5_issue", o_issue, 1);
      tick();
    end
    chk("cnt5_full", dut.cnt_q[5], 3);
    #1;
    chk("w5_full_dep", o_dep, 1);
    chk("w5_full_issue", o_issue, 0);
    wb_valid = 1; wb_dest = 4'd5; #1;
    chk("w5_full_wb_dep", o_dep, 1);
    tick();
    wb_valid = 0; #1;
    chk("w5_fourth_dep", o_dep, 0);
    chk("w5_fourth_issue", o_issue, 1);
    tick();
    chk("cnt5_still3", dut.cnt_q[5], 3);
    clear_in(); wb_valid = 1; wb_dest = 4'd5;
    tick(); tick(); tick();
    chk("cnt5_drain", dut.cnt_q[5], 0);

    // branch issue, resolve 4 cycles later
    clear_in(); de_valid = 1; isbr = 1; #1;
    chk("br_issue", o_issue, 1);
    chk("br_bstall_issue_cycle", o_bstall, 0);
    tick();
    clear_in(); de_valid = 1; mem_pc = 16'h0040;
    bstall_cnt = 0; asel_cnt = 0;
    for (int c = 1; c <= 8; c++) begin
      mem_res = (c == 4);
      #1;
      if (o_bstall) begin
        bstall_cnt++;
        chk("br_issue_blocked", o_issue, 0);
      end
      if (o_asel) begin
        asel_cnt++;
        chk("br_pc", o_pc, 16'h0040);
        chk("br_asel_cycle", c, 5);
      end
      tick();
    end
    chk("br_bstall_cycles", bstall_cnt, 5);
    chk("br_asel_cycles", asel_cnt, 1);

    // resolve in IDLE is ignored
    clear_in(); mem_res = 1; mem_pc = 16'h1234; #1;
    chk("idle_res_asel_now", o_asel, 0);
    tick();
    mem_res = 0; #1;
    chk("idle_res_asel", o_asel, 0);
    chk("idle_res_bstall", o_bstall, 0);
    chk("idle_res_pc", o_pc, 16'h0040);

    // async reset mid-branch with cnt[R1]=2
    writer(4'd1);
    tick(); tick();
    chk("cnt1_two", dut.cnt_q[1], 2);
    clear_in(); de_valid = 1; isbr = 1;
    tick();
    reader1(4'd1); #1;
    chk("pre_rst_dep", o_dep, 1);
    chk("pre_rst_bstall", o_bstall, 1);
    rst_n = 0; #1;
    chk("arst_dep", o_dep, 0);
    chk("arst_bstall", o_bstall, 0);
    chk("arst_asel", o_asel, 0);
    chk("arst_issue", o_issue, 0);
    chk("arst_pc", o_pc, 16'h0);
    chk("arst_cnt1", dut.cnt_q[1], 0);
    rst_n = 1;
    tick();
    #1;
    chk("post_rst_dep", o_dep, 0);
    chk("post_rst_issue", o_issue, 1);
    chk("post_rst_bstall", o_bstall, 0);
    tick();

    // lock low acts as synchronous reset
    writer(4'd6);
    tick();
    reader1(4'd6); lock = 0; #1;
    chk("lock_dep", o_dep, 0);
    chk("lock_issue", o_issue, 0);
    tick();
    lock = 1; #1;
    chk("unlock_dep", o_dep, 0);
    chk("unlock_issue", o_issue, 1);
    tick();
    clear_in(); de_valid = 1; isbr = 1;
    tick();
    clear_in(); #1;
    chk("lock_br_wait", o_bstall, 1);
    lock = 0; #1;
    chk("lock_br_bstall", o_bstall, 0);
    tick();
    lock = 1; #1;
    chk("unlock_br_bstall", o_bstall, 0);
    chk("unlock_br_asel", o_asel, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
